// File: rtl/instr_seq.sv
// Four-phase instruction sequencer/decoder: Q1-Q4 phase counter, instruction
// register, combinational decode and phase-gated strobes for ALU, register file, PC and stack.
module instr_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] prog_data,
    input  logic        alu_out_z,
    input  logic        alu_bit_test_res,
    output logic [1:0]  q_phase,
    output logic [3:0]  alu_op,
    output logic        alu_d,
    output logic        alu_d_wr_en,
    output logic        alu_status_wr_en,
    output logic        lf_sel_lit,
    output logic [7:0]  literal,
    output logic [6:0]  rf_addr,
    output logic        rf_rd_en,
    output logic [2:0]  bit_idx,
    output logic        bit_wr_en,
    output logic        bit_val,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [10:0] pc_load_addr,
    output logic        stack_push,
    output logic        stack_pop
);

    localparam logic [3:0] alu_op_add    = 4'd0;
    localparam logic [3:0] alu_op_sub    = 4'd1;
    localparam logic [3:0] alu_op_and    = 4'd2;
    localparam logic [3:0] alu_op_or     = 4'd3;
    localparam logic [3:0] alu_op_xor    = 4'd4;
    localparam logic [3:0] alu_op_com    = 4'd5;
    localparam logic [3:0] alu_op_inc    = 4'd6;
    localparam logic [3:0] alu_op_dec    = 4'd7;
    localparam logic [3:0] alu_op_rrf    = 4'd8;
    localparam logic [3:0] alu_op_rlf    = 4'd9;
    localparam logic [3:0] alu_op_swapf  = 4'd10;
    localparam logic [3:0] alu_op_passlf = 4'd11;
    localparam logic [3:0] alu_op_passw  = 4'd12;
    localparam logic [3:0] alu_op_clr    = 4'd13;

    typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

    phase_t      q_q;
    logic [13:0] ir_q;
    logic        flush_q;
    logic        flush_d;

    logic [3:0]  op;
    logic        d, lit_sel, rd, wr, st, bw, bset, ld, push, pop;
    logic        skip_z, skip_bc, skip_bs;

    always_comb begin
        op      = alu_op_add;
        d       = 1'b0;
        lit_sel = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        st      = 1'b0;
        bw      = 1'b0;
        bset    = 1'b0;
        ld      = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        skip_z  = 1'b0;
        skip_bc = 1'b0;
        skip_bs = 1'b0;
        unique case (ir_q[13:12])
            2'b00: begin
                if (ir_q[11:8] == 4'b0000) begin
                    if (ir_q[7]) begin
                        op = alu_op_passw;
                        d  = 1'b1;
                        rd = 1'b1;
                        wr = 1'b1;
                    end else if (ir_q == 14'h0008) begin
                        pop = 1'b1;
                    end
                end else begin
                    rd = 1'b1;
                    wr = 1'b1;
                    st = 1'b1;
                    d  = ir_q[7];
                    unique case (ir_q[11:8])
                        4'b0001: op = alu_op_clr;
                        4'b0010: op = alu_op_sub;
                        4'b0011: op = alu_op_dec;
                        4'b0100: op = alu_op_or;
                        4'b0101: op = alu_op_and;
                        4'b0110: op = alu_op_xor;
                        4'b0111: op = alu_op_add;
                        4'b1000: op = alu_op_passlf;
                        4'b1001: op = alu_op_com;
                        4'b1010: op = alu_op_inc;
                        4'b1011: begin op = alu_op_dec; st = 1'b0; skip_z = 1'b1; end
                        4'b1100: op = alu_op_rrf;
                        4'b1101: op = alu_op_rlf;
                        4'b1110: begin op = alu_op_swapf; st = 1'b0; end
                        4'b1111: begin op = alu_op_inc; st = 1'b0; skip_z = 1'b1; end
                        default: op = alu_op_add;
                    endcase
                end
            end
            2'b01: begin
                rd = 1'b1;
                unique case (ir_q[11:10])
                    2'b00: bw = 1'b1;
                    2'b01: begin bw = 1'b1; bset = 1'b1; end
                    2'b10: skip_bc = 1'b1;
                    2'b11: skip_bs = 1'b1;
                endcase
            end
            2'b10: begin
                ld   = 1'b1;
                push = ~ir_q[11];
            end
            2'b11: begin
                unique casez (ir_q[11:8])
                    4'b00??: begin op = alu_op_passlf; lit_sel = 1'b1; wr = 1'b1; end
                    4'b01??: begin op = alu_op_passlf; lit_sel = 1'b1; wr = 1'b1; pop = 1'b1; end
                    4'b1000: begin op = alu_op_or;  lit_sel = 1'b1; wr = 1'b1; st = 1'b1; end
                    4'b1001: begin op = alu_op_and; lit_sel = 1'b1; wr = 1'b1; st = 1'b1; end
                    4'b1010: begin op = alu_op_xor; lit_sel = 1'b1; wr = 1'b1; st = 1'b1; end
                    4'b110?: begin op = alu_op_sub; lit_sel = 1'b1; wr = 1'b1; st = 1'b1; end
                    4'b111?: begin op = alu_op_add; lit_sel = 1'b1; wr = 1'b1; st = 1'b1; end
                    default: op = alu_op_add;
                endcase
            end
        endcase
    end

    assign flush_d = (skip_z & alu_out_z) | (skip_bc & ~alu_bit_test_res)
                   | (skip_bs & alu_bit_test_res) | ld | pop;

    // flush is captured with the skip inputs at the Q3 edge and consumed at the Q4 edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= Q1;
            ir_q    <= '0;
            flush_q <= 1'b0;
        end else begin
            unique case (q_q)
                Q1: q_q <= Q2;
                Q2: q_q <= Q3;
                Q3: q_q <= Q4;
                Q4: q_q <= Q1;
            endcase
            if (q_q == Q3) flush_q <= flush_d;
            if (q_q == Q4) ir_q <= flush_q ? '0 : prog_data;
        end
    end

    assign q_phase          = q_q;
    assign alu_op           = op;
    assign alu_d            = d;
    assign lf_sel_lit       = lit_sel;
    assign literal          = ir_q[7:0];
    assign rf_addr          = ir_q[6:0];
    assign bit_idx          = ir_q[9:7];
    assign pc_load_addr     = ir_q[10:0];
    assign rf_rd_en         = rd & (q_q == Q2);
    assign alu_d_wr_en      = wr & (q_q == Q3);
    assign alu_status_wr_en = st & (q_q == Q3);
    assign bit_wr_en        = bw & (q_q == Q3);
    assign bit_val          = bset & (q_q == Q3);
    assign pc_load          = ld & (q_q == Q4);
    assign pc_inc           = ~ld & (q_q == Q4);
    assign stack_push       = push & (q_q == Q4);
    assign stack_pop        = pop & (q_q == Q4);

endmodule
